// File: rtl/tinker_pkg.sv
// Shared types and defaults for the tinker core memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   src_t       : which requester owns the in-flight transaction
//   mem_req_t   : captured request payload driven onto the memory port
package tinker_pkg;

  localparam int unsigned ADDR_W         = 64;
  localparam int unsigned IF_DATA_W      = 32;
  localparam int unsigned D_DATA_W       = 64;
  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;
  // Latency counter covers MEM_LAT up to 15.
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [D_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (fetch + data ports), the arbiter and the memory.
//   slave  : arbiter view (takes requests and m_rdata, drives grants/responses/memory strobe)
//   master : environment view (core requesters and memory array)
interface mem_port_arbiter_if;
  import tinker_pkg::*;

  logic                 if_req;
  logic [ADDR_W-1:0]    if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [IF_DATA_W-1:0] if_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_W-1:0]    d_addr;
  logic [D_DATA_W-1:0]  d_wdata;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [D_DATA_W-1:0]  d_rdata;

  logic                 m_en;
  logic                 m_we;
  logic [ADDR_W-1:0]    m_addr;
  logic [D_DATA_W-1:0]  m_wdata;
  logic [D_DATA_W-1:0]  m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/arb_prio_pick.sv
// Combinational grant select: data wins unless fetch has been starved STARVE_MAX times.
//   if_req, d_req : pending requests
//   starve_cnt    : consecutive data grants while fetch waited
//   idle          : arbiter can accept a request this cycle
//   if_gnt, d_gnt : one-hot (or zero) grant
module arb_prio_pick #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned STARVE_W   = 3
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  input  logic                idle,
  output logic                if_gnt,
  output logic                d_gnt
);

  logic force_if;

  always_comb begin
    force_if = (starve_cnt == STARVE_W'(STARVE_MAX));
    d_gnt    = idle & d_req & ~(if_req & force_if);
    if_gnt   = idle & if_req & (~d_req | force_if);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the fetch and data ports, one
// transaction in flight at a time.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch/data request+response ports and the memory port
module mem_port_arbiter
  import tinker_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  arb_state_t           state, state_next;
  logic [CNT_W-1:0]     lat_cnt, lat_cnt_next;
  logic [STARVE_W-1:0]  starve_cnt;
  src_t                 src;
  logic                 resp_we;
  logic                 idle, if_gnt, d_gnt, grant, resp_load;
  mem_req_t             pick;

  logic                 m_en_q, m_we_q;
  logic [ADDR_W-1:0]    m_addr_q;
  logic [D_DATA_W-1:0]  m_wdata_q;
  logic                 if_rvalid_q, d_rvalid_q;
  logic [IF_DATA_W-1:0] if_rdata_q;
  logic [D_DATA_W-1:0]  d_rdata_q;

  // RESP can accept the next request, giving MEM_LAT+2 throughput.
  assign idle = ~reset & ((state == IDLE) | (state == RESP));

  arb_prio_pick #(
    .STARVE_MAX (STARVE_MAX),
    .STARVE_W   (STARVE_W)
  ) u_prio_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .starve_cnt (starve_cnt),
    .idle       (idle),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt)
  );

  assign grant      = if_gnt | d_gnt;
  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // Payload of the winning requester.
  always_comb begin
    pick.we    = 1'b0;
    pick.addr  = bus.if_addr;
    pick.wdata = '0;
    if (d_gnt) begin
      pick.we    = bus.d_we;
      pick.addr  = bus.d_addr;
      pick.wdata = bus.d_wdata;
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    resp_load    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (grant) state_next = ISSUE;
      end
      ISSUE: begin
        lat_cnt_next = CNT_W'(MEM_LAT);
        state_next   = WAIT;
      end
      WAIT: begin
        lat_cnt_next = lat_cnt - CNT_W'(1);
        // Counter reaching zero this cycle: m_rdata is valid now.
        if (lat_cnt == CNT_W'(1)) begin
          resp_load  = 1'b1;
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && starve_cnt != STARVE_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Request capture, memory strobe and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      src         <= SRC_IF;
      resp_we     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      m_en_q      <= grant;
      m_we_q      <= grant & pick.we;
      if (grant) begin
        m_addr_q  <= pick.addr;
        m_wdata_q <= pick.wdata;
        src       <= d_gnt ? SRC_D : SRC_IF;
        resp_we   <= pick.we;
      end
      if_rvalid_q <= resp_load & (src == SRC_IF);
      d_rvalid_q  <= resp_load & (src == SRC_D);
      if (resp_load && src == SRC_IF) if_rdata_q <= bus.m_rdata[IF_DATA_W-1:0];
      if (resp_load && src == SRC_D)  d_rdata_q  <= resp_we ? '0 : bus.m_rdata;
    end
  end

  assign bus.m_en      = m_en_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-memory model behind the main DUT
// (MEM_LAT=2) plus two latency-only instances (MEM_LAT=1 and 15).
module tb_mem_port_arbiter;
  import tinker_pkg::*;

  localparam int LAT = 2;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   men_b2b = 0;
  logic men_prev = 1'b0;

  logic [31:0] exp_if[$];
  logic [63:0] exp_d[$];
  logic [31:0] exp_aux[$];

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus15 ();

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.MEM_LAT(15), .STARVE_MAX(4)) u_dut15 (.clk(clk), .reset(reset), .bus(bus15));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main memory: 512 KiB, byte addressed, wrapping; backdoor port for preload.
  logic [7:0]  mem [0:524287];
  logic [63:0] pipe [0:LAT-1];
  logic        bd_we;
  logic [63:0] bd_addr, bd_data;

  function automatic logic [63:0] rd8(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[19'(a + 64'(i))];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bd_we)
      for (int i = 0; i < 8; i++) mem[19'(bd_addr + 64'(i))] <= bd_data[8*i +: 8];
    if (bus.m_en === 1'b1 && bus.m_we === 1'b1)
      for (int i = 0; i < 8; i++) mem[19'(bus.m_addr + 64'(i))] <= bus.m_wdata[8*i +: 8];
    pipe[0] <= (bus.m_en === 1'b1) ? rd8(bus.m_addr) : 64'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.m_rdata = pipe[LAT-1];

  // Latency-only memories for the auxiliary builds.
  function automatic logic [63:0] aux_word(input logic [63:0] a);
    return {32'h0, 32'h5A00_0000 | {8'h0, a[23:0]}};
  endfunction

  logic [63:0] p1 [0:0];
  logic [63:0] p15 [0:14];
  always @(posedge clk) begin
    p1[0]  <= (bus1.m_en === 1'b1) ? aux_word(bus1.m_addr) : 64'h0;
    p15[0] <= (bus15.m_en === 1'b1) ? aux_word(bus15.m_addr) : 64'h0;
    for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
  end
  assign bus1.m_rdata  = p1[0];
  assign bus15.m_rdata = p15[14];

  // Tracks any two consecutive m_en cycles.
  always @(negedge clk) begin
    if (bus.m_en === 1'b1 && men_prev) men_b2b <= men_b2b + 1;
    men_prev <= (bus.m_en === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
    $fatal(1);
  end

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Waits up to 40 cycles for a response pulse; which: 0 if, 1 d, 2 aux1, 3 aux15.
  task automatic wait_sig(input int which, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((which == 0 && bus.if_rvalid === 1'b1) || (which == 1 && bus.d_rvalid === 1'b1) ||
          (which == 2 && bus1.if_rvalid === 1'b1) || (which == 3 && bus15.if_rvalid === 1'b1)) begin
        at = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [229:0] obs;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    obs = {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
           bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata};
    checks++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs); else passed++;
    checks++;
    if (u_dut.state !== IDLE || u_dut.starve_cnt !== '0 || u_dut.lat_cnt !== '0)
      $display("FAIL reset_state: got state %0d starve %0d cnt %0d expected 0 0 0",
               u_dut.state, u_dut.starve_cnt, u_dut.lat_cnt);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.m_en} !== 3'b000)
      $display("FAIL idle_quiet: got %b expected 000", {bus.if_gnt, bus.d_gnt, bus.m_en});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic fetch_once(input string name);
    int t0, at; bit ok; logic [31:0] e;
    bus.if_addr = 64'h2000; bus.if_req = 1'b1;
    exp_if.push_back(32'h8C40_0000);
    @(negedge clk);
    t0 = cyc;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10)
      $display("FAIL %s_gnt: got %b expected 10", name, {bus.if_gnt, bus.d_gnt});
    else passed++;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.m_en, bus.m_we, bus.m_addr} !== {2'b10, 64'h2000})
      $display("FAIL %s_issue: got en %b we %b addr %h expected 1 0 2000", name, bus.m_en, bus.m_we, bus.m_addr);
    else passed++;
    wait_sig(0, at, ok);
    checks++;
    if (!ok || at - t0 != LAT + 2)
      $display("FAIL %s_latency: got %0d expected %0d", name, at - t0, LAT + 2);
    else passed++;
    e = exp_if.pop_front();
    checks++;
    if (bus.if_rdata !== e) $display("FAIL %s_data: got %h expected %h", name, bus.if_rdata, e); else passed++;
    @(negedge clk);
    checks++;
    if (bus.if_rvalid !== 1'b0) $display("FAIL %s_pulse: got %b expected 0", name, bus.if_rvalid); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    fetch_once("fetch");
  endtask

  task automatic test_simultaneous();
    int t0, gc, at; bit ok; logic [63:0] ed; logic [31:0] ei;
    bus.if_addr = 64'h3000; bus.if_req = 1'b1;
    bus.d_addr = 64'h7FFF8; bus.d_we = 1'b0; bus.d_req = 1'b1;
    @(negedge clk);
    t0 = cyc;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b01)
      $display("FAIL both_first_gnt: got %b expected 01", {bus.if_gnt, bus.d_gnt});
    else passed++;
    if (bus.d_gnt === 1'b1) exp_d.push_back(64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    gc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.if_gnt === 1'b1) begin gc = cyc; break; end
    end
    checks++;
    if (gc - t0 != LAT + 2) $display("FAIL both_if_gnt_cycle: got %0d expected %0d", gc - t0, LAT + 2); else passed++;
    exp_if.push_back(32'hCAFE_F00D);
    checks++;
    if (bus.d_rvalid !== 1'b1) $display("FAIL both_d_rvalid: got %b expected 1", bus.d_rvalid); else passed++;
    if (exp_d.size() != 0) begin
      ed = exp_d.pop_front();
      checks++;
      if (bus.d_rdata !== ed) $display("FAIL both_d_data: got %h expected %h", bus.d_rdata, ed); else passed++;
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    wait_sig(0, at, ok);
    checks++;
    if (!ok || at - t0 != 2 * (LAT + 2))
      $display("FAIL both_if_rvalid_cycle: got %0d expected %0d", at - t0, 2 * (LAT + 2));
    else passed++;
    ei = exp_if.pop_front();
    checks++;
    if (bus.if_rdata !== ei) $display("FAIL both_if_data: got %h expected %h", bus.if_rdata, ei); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    int ngr; logic [5:0] got; int g_cyc[6]; bit chk_starve; logic [63:0] ed; logic [31:0] ei;
    ngr = 0; got = '0; chk_starve = 1'b0;
    foreach (g_cyc[i]) g_cyc[i] = 0;
    bus.if_addr = 64'h2000; bus.if_req = 1'b1;
    bus.d_addr = 64'h7FFF8; bus.d_we = 1'b0; bus.d_req = 1'b1;
    for (int k = 0; k < 120; k++) begin
      if (ngr >= 6 && exp_d.size() == 0 && exp_if.size() == 0) break;
      @(negedge clk);
      if (chk_starve) begin
        chk_starve = 1'b0;
        checks++;
        if (u_dut.starve_cnt !== '0)
          $display("FAIL starve_cleared: got %0d expected 0", u_dut.starve_cnt);
        else passed++;
      end
      if (bus.d_rvalid === 1'b1) begin
        checks++;
        if (exp_d.size() == 0) $display("FAIL starve_d_unexpected: got rvalid expected none");
        else begin
          ed = exp_d.pop_front();
          if (bus.d_rdata !== ed) $display("FAIL starve_d_data: got %h expected %h", bus.d_rdata, ed);
          else passed++;
        end
      end
      if (bus.if_rvalid === 1'b1) begin
        checks++;
        if (exp_if.size() == 0) $display("FAIL starve_if_unexpected: got rvalid expected none");
        else begin
          ei = exp_if.pop_front();
          if (bus.if_rdata !== ei) $display("FAIL starve_if_data: got %h expected %h", bus.if_rdata, ei);
          else passed++;
        end
      end
      if (ngr < 6 && bus.d_gnt === 1'b1) begin
        exp_d.push_back(64'h0123_4567_89AB_CDEF);
        g_cyc[ngr] = cyc; ngr++;
      end else if (ngr < 6 && bus.if_gnt === 1'b1) begin
        exp_if.push_back(32'h8C40_0000);
        got[ngr] = 1'b1; g_cyc[ngr] = cyc; ngr++;
        chk_starve = 1'b1;
        @(posedge clk); #1;
        bus.if_req = 1'b0;
      end
      if (ngr == 6 && bus.d_req === 1'b1) begin
        @(posedge clk); #1;
        bus.d_req = 1'b0;
      end
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    checks++;
    if (ngr != 6 || got !== 6'b01_0000)
      $display("FAIL starve_order: got %0d grants pattern %b expected 6 grants pattern 010000", ngr, got);
    else passed++;
    checks++;
    if (g_cyc[1] - g_cyc[0] != LAT + 2)
      $display("FAIL b2b_spacing: got %0d expected %0d", g_cyc[1] - g_cyc[0], LAT + 2);
    else passed++;
    checks++;
    if (exp_d.size() != 0 || exp_if.size() != 0)
      $display("FAIL starve_drain: got %0d pending expected 0", exp_d.size() + exp_if.size());
    else passed++;
    exp_d.delete(); exp_if.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int at; bit ok; logic [63:0] ed;
    bus.d_addr = 64'h100; bus.d_we = 1'b1; bus.d_wdata = 64'h1122_3344_5566_7788; bus.d_req = 1'b1;
    exp_d.push_back(64'h0);
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) $display("FAIL store_gnt: got %b expected 1", bus.d_gnt); else passed++;
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_wdata = 64'h0;
    @(negedge clk);
    checks++;
    if ({bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata} !== {2'b11, 64'h100, 64'h1122_3344_5566_7788})
      $display("FAIL store_issue: got en %b we %b addr %h wdata %h expected 1 1 100 1122334455667788",
               bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata);
    else passed++;
    wait_sig(1, at, ok);
    ed = exp_d.pop_front();
    checks++;
    if (!ok || bus.d_rdata !== ed) $display("FAIL store_resp: got ok %b data %h expected 1 %h", ok, bus.d_rdata, ed);
    else passed++;
    @(posedge clk); #1;
    bus.d_we = 1'b0; bus.d_req = 1'b1;
    exp_d.push_back(64'h1122_3344_5566_7788);
    @(negedge clk);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.m_en, bus.m_we} !== 2'b10) $display("FAIL load_issue: got %b expected 10", {bus.m_en, bus.m_we});
    else passed++;
    wait_sig(1, at, ok);
    ed = exp_d.pop_front();
    checks++;
    if (!ok || bus.d_rdata !== ed) $display("FAIL load_data: got ok %b data %h expected 1 %h", ok, bus.d_rdata, ed);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    logic [229:0] obs; int n_rv, n_men;
    bus.d_addr = 64'h7FFF8; bus.d_we = 1'b0; bus.d_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    obs = {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
           bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata};
    checks++;
    if (obs !== '0 || u_dut.state !== IDLE)
      $display("FAIL midreset_outputs: got %h state %0d expected 0 state 0", obs, u_dut.state);
    else passed++;
    n_rv = 0; n_men = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.d_rvalid === 1'b1) n_rv++;
      if (bus.m_en === 1'b1) n_men++;
      if (k == 1) begin @(posedge clk); #1; reset = 1'b0; end
    end
    checks++;
    if (n_rv != 0 || n_men != 0)
      $display("FAIL midreset_abort: got rvalid %0d m_en %0d expected 0 0", n_rv, n_men);
    else passed++;
    @(posedge clk); #1;
    fetch_once("postreset");
  endtask

  task automatic test_latency_builds();
    int t0, at; bit ok; logic [31:0] e;
    bus1.if_addr = 64'h40; bus1.if_req = 1'b1;
    exp_aux.push_back(32'h5A00_0040);
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    bus1.if_req = 1'b0;
    wait_sig(2, at, ok);
    checks++;
    if (!ok || at - t0 != 3) $display("FAIL lat1_latency: got %0d expected 3", at - t0); else passed++;
    e = exp_aux.pop_front();
    checks++;
    if (bus1.if_rdata !== e) $display("FAIL lat1_data: got %h expected %h", bus1.if_rdata, e); else passed++;
    @(posedge clk); #1;
    bus15.if_addr = 64'h80; bus15.if_req = 1'b1;
    exp_aux.push_back(32'h5A00_0080);
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    bus15.if_req = 1'b0;
    wait_sig(3, at, ok);
    checks++;
    if (!ok || at - t0 != 17) $display("FAIL lat15_latency: got %0d expected 17", at - t0); else passed++;
    e = exp_aux.pop_front();
    checks++;
    if (bus15.if_rdata !== e) $display("FAIL lat15_data: got %h expected %h", bus15.if_rdata, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_men_spacing();
    checks++;
    if (men_b2b != 0) $display("FAIL m_en_spacing: got %0d consecutive strobes expected 0", men_b2b);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus15.if_req = 1'b0; bus15.if_addr = '0; bus15.d_req = 1'b0; bus15.d_we = 1'b0; bus15.d_addr = '0; bus15.d_wdata = '0;
    test_reset();
    preload(64'h2000, 64'h0000_0000_8C40_0000);
    preload(64'h3000, 64'h0000_0000_CAFE_F00D);
    preload(64'h7FFF8, 64'h0123_4567_89AB_CDEF);
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store_load();
    test_reset_mid_wait();
    test_latency_builds();
    test_men_spacing();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
